// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
//   PC_W        : PC / fetch address width
//   INST_W      : instruction width
//   FETCH_WIDTH : instructions fetched and dispatched per cycle
package fetch_pkg;

  localparam int unsigned PC_W        = 8;
  localparam int unsigned INST_W      = 13;
  localparam int unsigned FETCH_WIDTH = 3;
  // Width of a per-cycle dequeue count (0..FETCH_WIDTH).
  localparam int unsigned DEQ_W       = $clog2(FETCH_WIDTH + 1);

  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue with FETCH_WIDTH write and read ports.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   flush_i    : clear the queue; overrides enq_i and deq_num_i
//   enq_i      : write FETCH_WIDTH entries at tail
//   wdata_i    : entries to write, index 0 goes to tail
//   deq_num_i  : number of entries retired from head this cycle
//   rdata_o    : entries at head+k, index 0 oldest
//   count_o    : occupancy
module inst_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic                               enq_i,
  input  fetch_entry_t [FETCH_WIDTH-1:0]     wdata_i,
  input  logic [DEQ_W-1:0]                   deq_num_i,
  output fetch_entry_t [FETCH_WIDTH-1:0]     rdata_o,
  output logic [CNT_W-1:0]                   count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;

  assign wr_en = enq_i && !flush_i;

  // Pointer and occupancy update; flush wins over any same-cycle traffic.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_num_i);
      tail_d  = wr_en ? tail_q + PTR_W'(FETCH_WIDTH) : tail_q;
      count_d = count_q + (wr_en ? CNT_W'(FETCH_WIDTH) : CNT_W'(0))
                - CNT_W'(deq_num_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        mem_q[tail_q + PTR_W'(k)] <= wdata_i[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      rdata_o[k] = mem_q[head_q + PTR_W'(k)];
    end
  end

  assign count_o = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

  // Pointer distance is ambiguous only when full (head == tail).
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
    (count_q == CNT_W'(DEPTH)) ||
    (PTR_W'(tail_q - head_q) == count_q[PTR_W-1:0]));

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the PC, captures FETCH_WIDTH instructions per cycle into
// a circular queue and presents up to FETCH_WIDTH of them to decode.
//   clk, rst_n        : clock, async active-low reset
//   pc_o              : fetch address to instruction memory
//   inst_i            : instructions at pc_o, pc_o+1, pc_o+2
//   redirect_valid_i  : flush queue, restart fetch at redirect_pc_i
//   redirect_pc_i     : restart PC
//   dec_ready_i       : decode takes all valid slots this cycle
//   dec_valid_o       : per-slot valid
//   dec_inst_o        : per-slot instruction, slot 0 oldest
//   dec_pc_o          : per-slot PC
//   count_o           : queue occupancy
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned     DEPTH    = 8,
  parameter  logic [PC_W-1:0] RESET_PC = '0,
  localparam int unsigned     CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic [PC_W-1:0]                     pc_o,
  input  logic [FETCH_WIDTH-1:0][INST_W-1:0]  inst_i,
  input  logic                                redirect_valid_i,
  input  logic [PC_W-1:0]                     redirect_pc_i,
  input  logic                                dec_ready_i,
  output logic [FETCH_WIDTH-1:0]              dec_valid_o,
  output logic [FETCH_WIDTH-1:0][INST_W-1:0]  dec_inst_o,
  output logic [FETCH_WIDTH-1:0][PC_W-1:0]    dec_pc_o,
  output logic [CNT_W-1:0]                    count_o
);

  logic [PC_W-1:0]                  pc_q, pc_d;
  logic [CNT_W-1:0]                 count;
  logic [DEQ_W-1:0]                 deq_num;
  logic                             enq;
  fetch_entry_t [FETCH_WIDTH-1:0]   wdata;
  fetch_entry_t [FETCH_WIDTH-1:0]   rdata;

  // Decode retires min(count, FETCH_WIDTH) or nothing.
  always_comb begin
    deq_num = '0;
    if (dec_ready_i) begin
      deq_num = (count >= CNT_W'(FETCH_WIDTH)) ? DEQ_W'(FETCH_WIDTH)
                                               : DEQ_W'(count);
    end
  end

  // Slots freed by this cycle's dequeue count as free space.
  assign enq = !redirect_valid_i &&
               ((count - CNT_W'(deq_num)) <= CNT_W'(DEPTH - FETCH_WIDTH));

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (enq) begin
      pc_d = pc_q + PC_W'(FETCH_WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wdata[k].pc   = pc_q + PC_W'(k);
      wdata[k].inst = inst_i[k];
    end
  end

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid_i),
    .enq_i     (enq),
    .wdata_i   (wdata),
    .deq_num_i (deq_num),
    .rdata_o   (rdata),
    .count_o   (count)
  );

  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      dec_valid_o[k] = count > CNT_W'(k);
      dec_inst_o[k]  = rdata[k].inst;
      dec_pc_o[k]    = rdata[k].pc;
    end
  end

  assign pc_o    = pc_q;
  assign count_o = count;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import fetch_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic [PC_W-1:0]                    pc_o;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] inst_i;
  logic                               redirect_valid_i;
  logic [PC_W-1:0]                    redirect_pc_i;
  logic                               dec_ready_i;
  logic [FETCH_WIDTH-1:0]             dec_valid_o;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] dec_inst_o;
  logic [FETCH_WIDTH-1:0][PC_W-1:0]   dec_pc_o;
  logic [3:0]                         count_o;

  fetch_buffer #(.DEPTH(8), .RESET_PC(8'h00)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_o             (pc_o),
    .inst_i           (inst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .dec_ready_i      (dec_ready_i),
    .dec_valid_o      (dec_valid_o),
    .dec_inst_o       (dec_inst_o),
    .dec_pc_o         (dec_pc_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  // Instruction memory model: combinational read at pc_o+k.
  logic [INST_W-1:0] imem [256];
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      inst_i[k] = imem[8'(pc_o + 8'(k))];
    end
  end

  // Reference model: FIFO of fetched entries plus the fetch PC.
  fetch_entry_t    mq [$];
  logic [PC_W-1:0] mpc;
  int vectors = 0;
  int errs    = 0;

  task automatic check(input string tag, input int unsigned obs,
                       input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count_o), 32'(mq.size()));
    check("pc", 32'(pc_o), 32'(mpc));
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      check("valid", 32'(dec_valid_o[k]), 32'(mq.size() > k));
      if (mq.size() > k) begin
        check("slot_pc", 32'(dec_pc_o[k]), 32'(mq[k].pc));
        check("slot_inst", 32'(dec_inst_o[k]), 32'(mq[k].inst));
      end
    end
  endtask

  task automatic model_cycle(input logic rdy, input logic redir,
                             input logic [PC_W-1:0] rpc);
    int n   = mq.size();
    int deq = rdy ? ((n < 3) ? n : 3) : 0;
    if (redir) begin
      mq.delete();
      mpc = rpc;
    end else begin
      repeat (deq) void'(mq.pop_front());
      if (8 - n + deq >= 3) begin
        for (int k = 0; k < 3; k++) begin
          mq.push_back('{pc: mpc + 8'(k), inst: imem[8'(mpc + 8'(k))]});
        end
        mpc = mpc + 8'd3;
      end
    end
  endtask

  // Drive one cycle's inputs at a negedge, then check at the next negedge.
  task automatic step(input logic rdy, input logic redir,
                      input logic [PC_W-1:0] rpc);
    dec_ready_i      = rdy;
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    model_cycle(rdy, redir, rpc);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 13'($urandom);
    rst_n            = 1'b0;
    dec_ready_i      = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    mpc              = 8'h00;
    #12;
    check_all();
    check("rst_valid", 32'(dec_valid_o), 32'd0);

    // Release reset with decode stalled.
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    step(1'b0, 1'b0, '0);
    check("first_count", 32'(count_o), 32'd3);
    check("first_pc", 32'(pc_o), 32'd3);
    check("first_valid", 32'(dec_valid_o), 32'd7);
    check("first_slot2_pc", 32'(dec_pc_o[2]), 32'd2);

    // Fill until stalled, then drain at full rate.
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("stall_count", 32'(count_o), 32'd6);
    check("stall_pc", 32'(pc_o), 32'd6);
    step(1'b1, 1'b0, '0);
    check("drain_count", 32'(count_o), 32'd6);
    check("drain_pc", 32'(pc_o), 32'd9);
    check("drain_slot0_pc", 32'(dec_pc_o[0]), 32'd3);

    // Redirect with ready high while count=6.
    step(1'b1, 1'b1, 8'h40);
    check("redir_count", 32'(count_o), 32'd0);
    check("redir_pc", 32'(pc_o), 32'h40);
    step(1'b1, 1'b0, '0);
    check("redir_slot0_pc", 32'(dec_pc_o[0]), 32'h40);

    // Steady state across pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    check("steady_count", 32'(count_o), 32'd3);

    // PC wrap through 0xFE.
    step(1'b1, 1'b1, 8'hFE);
    step(1'b1, 1'b0, '0);
    check("wrap_slot1_pc", 32'(dec_pc_o[1]), 32'hFF);
    check("wrap_slot2_pc", 32'(dec_pc_o[2]), 32'h00);
    check("wrap_pc", 32'(pc_o), 32'h01);
    check("wrap_inst2", 32'(dec_inst_o[2]), 32'(imem[0]));

    // Asynchronous reset mid-stream with count=6.
    step(1'b0, 1'b0, '0);
    check("pre_rst_count", 32'(count_o), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    mpc = 8'h00;
    check_all();
    check("async_rst_valid", 32'(dec_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Front-end fetch stage directly upstream of the instruction memory and downstream of it toward decode. Owns the PC and drives the 8-bit fetch address to the instruction memory. Captures the 3 returned 13-bit instructions with their PCs into a circular instruction queue. Presents up to 3 queued instructions per cycle to decode, with backpressure and a redirect/flush path.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2*FETCH_WIDTH
FETCH_WIDTH, 3, instructions fetched/dispatched per cycle (fixed by memory port count)
INST_W, 13, instruction width
PC_W, 8, PC/address width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_o  out  PC_W  fetch address to instruction memory (registered PC)
inst_i  in  FETCH_WIDTH x INST_W  combinational instructions at pc_o, pc_o+1, pc_o+2
redirect_valid_i  in  1  flush queue and restart fetch
redirect_pc_i  in  PC_W  restart PC
dec_ready_i  in  1  decode accepts all currently valid slots this cycle
dec_valid_o  out  FETCH_WIDTH  slot k valid
dec_inst_o  out  FETCH_WIDTH x INST_W  instruction per slot, slot 0 oldest
dec_pc_o  out  FETCH_WIDTH x PC_W  PC per slot
count_o  out  log2(DEPTH)+1  queue occupancy (debug/verification)

Behaviour:
- Reset, async on rst_n low: pc=RESET_PC, head=tail=0, count=0. dec_valid_o=0. Storage is not reset. Outputs depend only on these registers, so they settle immediately.
- Decode outputs are combinational from the queue head:
  - dec_valid_o[k] = (count > k).
  - Slot k reads entry (head+k) mod DEPTH.
  - Invalid slots' data is don't-care.
- Dequeue: deq_num = dec_ready_i ? min(count,3) : 0. Decode must consume all valid slots or none.
- Enqueue condition: enq = !redirect_valid_i && (DEPTH - count + deq_num >= 3). Freed slots from the same-cycle dequeue count toward free space.
- On enqueue:
  - Write entries tail, tail+1, tail+2 (mod DEPTH) with {inst_i[k], pc+k mod 2^PC_W}.
  - tail += 3; pc += 3 (mod 2^PC_W).
- Without enqueue: pc holds and inst_i is ignored.
- count_next = count + (enq ? 3 : 0) - deq_num. head += deq_num.
- Redirect has priority over everything else:
  - Next cycle: head=tail=0, count=0, pc=redirect_pc_i.
  - Any same-cycle dequeue is discarded. Decode must ignore it; the redirect source owns the squash.
  - No enqueue that cycle.
  - The first instructions from the new PC are visible at decode 2 cycles after redirect asserts: one cycle to load pc, one to enqueue.
- Latency: instructions fetched at pc in cycle N are valid at decode in cycle N+1. There is no bypass.
- Throughput: with dec_ready_i held high, steady state is 3 instructions/cycle. Count stays at 3 once filled.
- Boundaries:
  - PC wrap: pc=255 yields entries with PCs 255, 0, 1, and next pc=2. The instruction memory's index arithmetic is the memory's concern.
  - Pointer wrap: head and tail wrap mod DEPTH.
  - Full: count never exceeds DEPTH.
  - Empty: dec_valid_o=0 and dec_ready_i has no effect.
- Reset mid-operation clears the queue and pc asynchronously; in-flight data is lost.
- Assertions:
  - count <= DEPTH.
  - ((tail - head) mod DEPTH) matches count except when count==DEPTH.

Decomposition:
- Package fetch_pkg holds:
  - Constants PC_W, INST_W, FETCH_WIDTH.
  - typedef fetch_entry_t {logic [PC_W-1:0] pc; logic [INST_W-1:0] inst;}.
  - typedef logic [INST_W-1:0] inst_t.
- A sub-module inst_queue is natural: multi-port circular storage, head/tail/count, 3-write/3-read. PC register and enqueue/redirect control stay in fetch_buffer.

Test Plan:
- Reset with RESET_PC=0, then release with dec_ready_i=0 -> cycle 1 pc_o=0 and count=0. Next edge: count=3, pc_o=3, dec_pc_o={0,1,2}, dec_valid_o=3'b111.
- Hold dec_ready_i=0 -> count goes 3, 6, then stalls (free=2), pc_o stays 6. Raise dec_ready_i=1 -> count 6 -> 6 (deq 3, enq 3), pc_o 6 -> 9. Decode sees PCs 0,1,2 then 3,4,5 in order.
- dec_ready_i=1 continuously from reset -> every cycle after the first, 3 valid slots with consecutive PCs and count=3. Confirms 3 instructions/cycle, including head/tail wrap past entry 7.
- Redirect with redirect_pc_i=0x40 while count=6 and dec_ready_i=1 -> next cycle count=0, dec_valid_o=0, pc_o=0x40. The following cycle dec_pc_o={0x40,0x41,0x42}. The head did not advance from the discarded dequeue.
- Redirect to 0xFE with ready high -> entries PCs 0xFE, 0xFF, 0x00, next pc_o=0x01, dec_inst_o matches memory words 254, 255, 0.
- Assert rst_n low mid-stream with count=6 -> count_o=0, dec_valid_o=0, pc_o=RESET_PC immediately, without waiting for a clock edge.
